i2c_slave_block: RTL and testbench
==================================

I2C_SLAVE_BLOCK -- requirements
Module: i2c_slave_block

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, 7-bit address this responder acknowledges.
REQ-002 SHALL have port i2c_core_clock_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port scl_i  input  1  bus SCL, asynchronous to clock.
REQ-005 SHALL have port sda_i  input  1  bus SDA, asynchronous to clock.
REQ-006 SHALL have port sda_oe_o  output  1  1 = pull SDA low; 0 = release (open-drain, top level tristates).
REQ-007 SHALL have port data_i  input  8  head byte of transmit FIFO.
REQ-008 SHALL have port trans_fifo_empty_i  input  1  transmit FIFO empty.
REQ-009 SHALL have port read_fifo_en_o  output  1  one-cycle pop pulse to transmit FIFO.
REQ-010 SHALL have port data_o  output  8  last received write byte.
REQ-011 SHALL have port write_fifo_en_o  output  1  one-cycle push pulse to receive FIFO, qualifies data_o.
REQ-012 SHALL have port rev_fifo_full_i  input  1  receive FIFO full.
REQ-013 SHALL have port busy_o  output  1  1 from address match until STOP/return to IDLE.
REQ-014 SHALL have port rw_o  output  1  R/W bit of the current addressed transfer (1 = read).

Function
REQ-015 SHALL synchronise scl_i, sda_i through two flops each, then one history flop for edge detect; bus events act 3 cycles after the pin change; core clock >= 8x SCL required.
REQ-016 SHALL detect START as synced SDA falling while synced SCL high, STOP as synced SDA rising while synced SCL high; both override any state.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-018 SHALL go to ADDR on START from any state (repeated START included), clearing the 3-bit bit counter and shift register.
REQ-019 SHALL go to IDLE on STOP from any state, releasing SDA (sda_oe_o = 0) on the same cycle and clearing busy_o.
REQ-020 SHALL sample SDA MSB-first on each SCL rising edge and change sda_oe_o only on the cycle after an SCL falling edge is detected.
REQ-021 ADDR: after 8th rising edge, on match of bits[7:1] with SLAVE_ADDR SHALL latch rw_o, set busy_o, go to ADDR_ACK; on mismatch SHALL go to IDLE, SDA untouched.
REQ-022 ADDR_ACK: SHALL drive sda_oe_o=1 from the falling edge after bit 8 to the falling edge after the 9th clock; then WR_DATA if rw_o=0, else RD_DATA.
REQ-023 On entering RD_DATA SHALL load shift register with data_i and pulse read_fifo_en_o once if trans_fifo_empty_i=0; if empty SHALL load 8'hFF and not pulse.
REQ-024 RD_DATA: SHALL drive sda_oe_o = ~shift[7] per bit, shift on each falling edge; after 8 bits release SDA, go to RD_ACK.
REQ-025 RD_ACK: on 9th rising edge SDA=0 (master ACK) SHALL return to RD_DATA at next falling edge with a new load per REQ-023; SDA=1 (NACK) SHALL go to IDLE with busy_o held until STOP.
REQ-026 WR_DATA: on 8th rising edge SHALL update data_o; if rev_fifo_full_i=0 pulse write_fifo_en_o for exactly one cycle and ACK in WR_ACK, else no pulse and NACK (SDA released).
REQ-027 WR_ACK: after ACK slot SHALL return to WR_DATA; after NACK slot SHALL go to IDLE.
REQ-028 read_fifo_en_o and write_fifo_en_o SHALL never be high for more than one consecutive cycle, and never simultaneously.
REQ-029 Glitch-free: SDA change while SCL high inside a data byte SHALL be treated as START/STOP per REQ-016, not data.

Reset
REQ-030 With reset_n_i=0 SHALL immediately force state IDLE, sda_oe_o=0, read_fifo_en_o=0, write_fifo_en_o=0, busy_o=0, rw_o=0, data_o=8'h00, counters and synchronisers to idle-bus value (1); mid-transfer reset SHALL abandon the transfer and await a new START.

Verification
REQ-031 Write: START, 0xA0, 0x3C, STOP, FIFO not full -> ACK on both 9th clocks, one write_fifo_en_o pulse with data_o=8'h3C, busy_o 0 after STOP.
REQ-032 Address miss: START, 0xA2 -> sda_oe_o stays 0 for whole transfer, no FIFO pulses, busy_o=0.
REQ-033 Read: FIFO holds 0x5A,0xC3; START, 0xA1, master ACK then NACK -> SDA bits 01011010 then 11000011, two read_fifo_en_o pulses, IDLE after NACK.
REQ-034 Read with empty FIFO: START, 0xA1 -> byte 8'hFF on SDA, no read_fifo_en_o pulse.
REQ-035 Write with rev_fifo_full_i=1: START, 0xA0, 0x11 -> address ACKed, data NACKed, no write_fifo_en_o, state IDLE.
REQ-036 Repeated START: write 0xA0,0x07 then Sr, 0xA1 read -> rw_o changes 0 to 1, read byte driven; reset_n_i low mid-byte -> all outputs at REQ-030 values next edge-independent.

Source files
------------

// File: rtl/i2c_slave_block.sv
// I2C slave responder: synchronised bus sampling, address match, byte write into an
// external receive FIFO and byte read from an external transmit FIFO.
module i2c_slave_block #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic [7:0] data_i,
  input  logic       trans_fifo_empty_i,
  output logic       read_fifo_en_o,
  output logic [7:0] data_o,
  output logic       write_fifo_en_o,
  input  logic       rev_fifo_full_i,
  output logic       busy_o,
  output logic       rw_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_h;
  logic        sda_s1, sda_s2, sda_h;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        phase;
  logic        ack_ok;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  tx_byte;

  always_ff @(posedge i2c_core_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign tx_byte   = trans_fifo_empty_i ? 8'hFF : data_i;

  always_ff @(posedge i2c_core_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift           <= '0;
      phase           <= 1'b0;
      ack_ok          <= 1'b0;
      sda_oe_o        <= 1'b0;
      read_fifo_en_o  <= 1'b0;
      write_fifo_en_o <= 1'b0;
      data_o          <= '0;
      busy_o          <= 1'b0;
      rw_o            <= 1'b0;
    end else begin
      read_fifo_en_o  <= 1'b0;
      write_fifo_en_o <= 1'b0;
      // Bus conditions take priority so an SDA change with SCL high is never data.
      if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        shift    <= '0;
        phase    <= 1'b0;
        sda_oe_o <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift[6:0] == SLAVE_ADDR) begin
                  rw_o   <= sda_s2;
                  busy_o <= 1'b1;
                  phase  <= 1'b0;
                  state  <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          // phase 0: waiting for the fall after bit 8; phase 1: ACK slot in progress.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe_o <= 1'b1;
                phase    <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= '0;
                if (rw_o) begin
                  state          <= RD_DATA;
                  shift          <= tx_byte;
                  sda_oe_o       <= ~tx_byte[7];
                  read_fifo_en_o <= ~trans_fifo_empty_i;
                end else begin
                  state    <= WR_DATA;
                  sda_oe_o <= 1'b0;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_o          <= {shift[6:0], sda_s2};
                write_fifo_en_o <= ~rev_fifo_full_i;
                ack_ok          <= ~rev_fifo_full_i;
                phase           <= 1'b0;
                state           <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe_o <= ack_ok;
                phase    <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                phase    <= 1'b0;
                bit_cnt  <= '0;
                state    <= ack_ok ? WR_DATA : IDLE;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= '0;
                phase    <= 1'b0;
                state    <= RD_ACK;
              end else begin
                shift    <= {shift[6:0], 1'b0};
                sda_oe_o <= ~shift[6];
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2) state <= IDLE;
              else        phase <= 1'b1;
            end else if (scl_fall && phase) begin
              phase          <= 1'b0;
              state          <= RD_DATA;
              shift          <= tx_byte;
              sda_oe_o       <= ~tx_byte[7];
              read_fifo_en_o <= ~trans_fifo_empty_i;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_block.sv
// Bench for i2c_slave_block: a bit-banged I2C master with open-drain bus, a directed
// vector table, hand-written corner sequences and randomized transfers vs a transfer model.
`timescale 1ns/1ps
module tb_i2c_slave_block;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rd_en, wr_en, busy, rw;
  logic [7:0] data_i_w, data_o_w;
  logic       empty;
  logic       full = 1'b0;

  logic [7:0]  fifo_mem [256];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic [7:0]  rx_mem [256];
  int unsigned push_cnt = 0;
  int unsigned viol = 0;
  int unsigned oe_cnt = 0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  logic       wack [4];
  logic       aack;

  always #5 clk = ~clk;
  assign sda_bus  = sda_drv & ~sda_oe;
  assign data_i_w = fifo_mem[rd_ptr[7:0]];
  assign empty    = (rd_ptr == wr_ptr);

  i2c_slave_block #(.SLAVE_ADDR(7'h50)) dut (
    .i2c_core_clock_i   (clk),
    .reset_n_i          (rst_n),
    .scl_i              (scl_drv),
    .sda_i              (sda_bus),
    .sda_oe_o           (sda_oe),
    .data_i             (data_i_w),
    .trans_fifo_empty_i (empty),
    .read_fifo_en_o     (rd_en),
    .data_o             (data_o_w),
    .write_fifo_en_o    (wr_en),
    .rev_fifo_full_i    (full),
    .busy_o             (busy),
    .rw_o               (rw)
  );

  // FIFO side models and pulse-rule monitor
  always @(posedge clk) begin
    if (rd_en) rd_ptr <= rd_ptr + 1;
    if (wr_en) begin
      rx_mem[push_cnt[7:0]] <= data_o_w;
      push_cnt <= push_cnt + 1;
    end
    if ((rd_en && wr_en) || (rd_en && prev_rd) || (wr_en && prev_wr)) viol <= viol + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    prev_rd <= rd_en;
    prev_wr <= wr_en;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic bus_bit(input logic b, output logic s);
    #100 sda_drv = b;
    #100 scl_drv = 1'b1;
    #100 s = sda_bus;
    #100 scl_drv = 1'b0;
  endtask

  task automatic bus_start();
    #100 sda_drv = 1'b1;
    #100 scl_drv = 1'b1;
    #100 sda_drv = 1'b0;
    #100 scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    #100 sda_drv = 1'b0;
    #100 scl_drv = 1'b1;
    #100 sda_drv = 1'b1;
    #200;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~mack, s);
  endtask

  // START, address, then n data bytes (last read byte NACKed); no STOP.
  task automatic run_xfer(input logic [7:0] ab, input int n);
    for (int i = 0; i < 4; i++) begin
      rbuf[i] = 'x;
      wack[i] = 1'b0;
    end
    bus_start();
    send_byte(ab, aack);
    if (aack) begin
      if (!ab[0]) begin
        for (int i = 0; i < n; i++) begin
          send_byte(wbuf[i], wack[i]);
          if (!wack[i]) break;
        end
      end else begin
        for (int i = 0; i < n; i++) recv_byte(i != n - 1, rbuf[i]);
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] ab;
    logic [7:0] b0;
    logic       full;
    logic       load;
    logic       e_aack;
    logic       e_dack;
    logic [7:0] e_rd;
    int         e_push;
    int         e_pop;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int unsigned b_pop, b_push, b_oe;
    logic s;
    logic [7:0] ab;
    logic [7:0] exp_q [4];
    logic match;
    int n, k;

    tbl[0] = '{"wr_3c",     8'hA0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1, 0};
    tbl[1] = '{"miss_a2",   8'hA2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[2] = '{"rd_empty",  8'hA1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 0};
    tbl[3] = '{"wr_full",   8'hA0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
    tbl[4] = '{"rd_96",     8'hA1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96, 0, 1};
    tbl[5] = '{"miss_rd",   8'hA3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};

    for (int i = 0; i < 256; i++) fifo_mem[i] = 8'($urandom);

    #22;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 0);
    check("rst_data_o", data_o_w, 0);
    #30 rst_n = 1'b1;
    #200;

    foreach (tbl[v]) begin
      b_pop = rd_ptr; b_push = push_cnt; b_oe = oe_cnt;
      full = tbl[v].full;
      if (tbl[v].load) begin
        fifo_mem[wr_ptr[7:0]] = tbl[v].b0;
        wr_ptr++;
      end
      wbuf[0] = tbl[v].b0;
      run_xfer(tbl[v].ab, 1);
      check({tbl[v].name, "_aack"}, aack, tbl[v].e_aack);
      if (tbl[v].e_aack && !tbl[v].ab[0]) begin
        check({tbl[v].name, "_dack"}, wack[0], tbl[v].e_dack);
        check({tbl[v].name, "_data_o"}, data_o_w, tbl[v].b0);
      end
      if (tbl[v].e_aack && tbl[v].ab[0]) check({tbl[v].name, "_rd"}, rbuf[0], tbl[v].e_rd);
      if (tbl[v].e_push > 0) check({tbl[v].name, "_rx"}, rx_mem[b_push[7:0]], tbl[v].b0);
      check({tbl[v].name, "_busy"}, busy, tbl[v].e_aack);
      bus_stop();
      check({tbl[v].name, "_busy_stop"}, busy, 0);
      check({tbl[v].name, "_push"}, push_cnt - b_push, tbl[v].e_push);
      check({tbl[v].name, "_pop"}, rd_ptr - b_pop, tbl[v].e_pop);
      if (!tbl[v].e_aack) check({tbl[v].name, "_oe_quiet"}, oe_cnt - b_oe, 0);
    end
    full = 1'b0;

    // Two-byte read: ACK then NACK
    b_pop = rd_ptr;
    fifo_mem[wr_ptr[7:0]] = 8'h5A; wr_ptr++;
    fifo_mem[wr_ptr[7:0]] = 8'hC3; wr_ptr++;
    run_xfer(8'hA1, 2);
    check("rd2_aack", aack, 1);
    check("rd2_b0", rbuf[0], 8'h5A);
    check("rd2_b1", rbuf[1], 8'hC3);
    check("rd2_pop", rd_ptr - b_pop, 2);
    check("rd2_busy_held", busy, 1);
    check("rd2_oe_released", sda_oe, 0);
    bus_stop();
    check("rd2_busy_stop", busy, 0);

    // Repeated START: write then read without STOP
    wbuf[0] = 8'h07;
    b_push = push_cnt;
    run_xfer(8'hA0, 1);
    check("sr_wr_ack", wack[0], 1);
    check("sr_rw0", rw, 0);
    check("sr_rx", rx_mem[b_push[7:0]], 8'h07);
    fifo_mem[wr_ptr[7:0]] = 8'h3E; wr_ptr++;
    run_xfer(8'hA1, 1);
    check("sr_aack", aack, 1);
    check("sr_rw1", rw, 1);
    check("sr_rd", rbuf[0], 8'h3E);
    bus_stop();

    // Reset in the middle of a read byte that drives SDA low
    fifo_mem[wr_ptr[7:0]] = 8'h00; wr_ptr++;
    bus_start();
    send_byte(8'hA1, aack);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    #150;
    check("mid_oe_before_rst", sda_oe, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_oe", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rw", rw, 0);
    check("mid_rst_data_o", data_o_w, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_wr_en", wr_en, 0);
    scl_drv = 1'b1; sda_drv = 1'b1;
    #200 rst_n = 1'b1;
    #200;
    wbuf[0] = 8'h42;
    run_xfer(8'hA0, 1);
    check("post_rst_ack", wack[0], 1);
    check("post_rst_data_o", data_o_w, 8'h42);
    bus_stop();

    // Randomized transfers vs transfer-level model
    for (int t = 0; t < 20; t++) begin
      ab    = {($urandom_range(1, 0) != 0) ? 7'h50 : 7'($urandom), 1'($urandom)};
      match = (ab[7:1] == 7'h50);
      n     = int'($urandom_range(3, 1));
      k     = int'($urandom_range(n, 0));
      full  = ($urandom_range(3, 0) == 0);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      if (match && ab[0]) begin
        for (int i = 0; i < k; i++) begin
          fifo_mem[wr_ptr[7:0]] = 8'($urandom);
          exp_q[i] = fifo_mem[wr_ptr[7:0]];
          wr_ptr++;
        end
      end
      b_pop = rd_ptr; b_push = push_cnt; b_oe = oe_cnt;
      run_xfer(ab, n);
      check("rnd_aack", aack, match);
      check("rnd_busy", busy, match);
      if (match) check("rnd_rw", rw, ab[0]);
      if (match && !ab[0]) begin
        if (full) begin
          check("rnd_wr_nack", wack[0], 0);
          check("rnd_push_full", push_cnt - b_push, 0);
        end else begin
          for (int i = 0; i < n; i++) begin
            check("rnd_wr_ack", wack[i], 1);
            check("rnd_rx", rx_mem[8'(b_push + i)], wbuf[i]);
          end
          check("rnd_push", push_cnt - b_push, n);
        end
      end
      if (match && ab[0]) begin
        for (int i = 0; i < n; i++) check("rnd_rd", rbuf[i], (i < k) ? exp_q[i] : 8'hFF);
        check("rnd_pop", rd_ptr - b_pop, k);
      end
      if (!match) begin
        check("rnd_miss_oe", oe_cnt - b_oe, 0);
        check("rnd_miss_push", push_cnt - b_push, 0);
        check("rnd_miss_pop", rd_ptr - b_pop, 0);
      end
      bus_stop();
      check("rnd_busy_stop", busy, 0);
    end
    full = 1'b0;

    check("pulse_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
